// File: rtl/record_core.sv
// Audio capture engine: buffers codec samples in a small FIFO and writes them to SDRAM as a clip
// (length word at base, samples at base+1..base+N). Define REC_DECIMATE_EN to keep only every other sample.
module record_core #(
    parameter int                ADDR_W     = 23,
    parameter int                DATA_W     = 32,
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] MAX_LEN    = 23'h3FFFFF
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              rec_start,
    input  logic [ADDR_W-1:0] rec_base,
    input  logic              rec_stop,
    output logic              rec_busy,
    output logic              rec_done,
    output logic [ADDR_W-1:0] rec_length,
    output logic              rec_overflow,
    output logic              rec_write,
    output logic [ADDR_W-1:0] rec_addr,
    output logic [DATA_W-1:0] rec_writedata,
    input  logic              rec_sdram_finished,
    input  logic              rec_audio_valid,
    input  logic [DATA_W-1:0] rec_audio_data,
    output logic              rec_audio_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int SUM_W = ADDR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RECORD    = 3'd1,
        S_FLUSH     = 3'd2,
        S_WRITE_LEN = 3'd3,
        S_DONE      = 3'd4
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_count;
    logic [DATA_W-1:0] r_fifo [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [OCC_W-1:0]  r_occ;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_writedata;
    logic [ADDR_W-1:0] r_length;
    logic              r_overflow;
`ifdef REC_DECIMATE_EN
    logic              r_phase;
`endif

    logic              w_start;
    logic              w_accept;
    logic              w_keep;
    logic              w_full;
    logic              w_room;
    logic              w_push;
    logic              w_drop;
    logic              w_in_xfer;
    logic              w_pop;
    logic              w_issue;
    logic              w_drained;
    logic              w_enter_len;
    logic              w_len_ack;
    logic              w_limit;
    logic [SUM_W-1:0]  w_total;
    logic [SUM_W-1:0]  w_total_next;

    assign w_start   = (r_state == S_IDLE) && rec_start;
    assign w_accept  = rec_audio_valid && (r_state == S_RECORD);
`ifdef REC_DECIMATE_EN
    assign w_keep    = w_accept && !r_phase;
`else
    assign w_keep    = w_accept;
`endif
    assign w_full    = (r_occ == OCC_FULL);
    // Accepted count = samples already in SDRAM plus samples still buffered
    assign w_total      = {1'b0, r_count} + SUM_W'(r_occ);
    assign w_room       = (w_total < {1'b0, MAX_LEN});
    assign w_push       = w_keep && !w_full && w_room;
    assign w_drop       = w_keep && w_full;
    assign w_total_next = w_total + SUM_W'(w_push);
    assign w_limit      = (w_total_next >= {1'b0, MAX_LEN});

    assign w_in_xfer   = (r_state == S_RECORD) || (r_state == S_FLUSH);
    assign w_pop       = w_in_xfer && r_write && rec_sdram_finished;
    assign w_issue     = w_in_xfer && !r_write && (r_occ != {OCC_W{1'b0}});
    assign w_drained   = !r_write && (r_occ == {OCC_W{1'b0}});
    assign w_enter_len = (r_state == S_FLUSH) && w_drained;
    assign w_len_ack   = (r_state == S_WRITE_LEN) && r_write && rec_sdram_finished;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (rec_start) begin
                    w_state_next = S_RECORD;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            S_RECORD: begin
                if (rec_stop || w_limit) begin
                    w_state_next = S_FLUSH;
                end else begin
                    w_state_next = S_RECORD;
                end
            end
            S_FLUSH: begin
                if (w_drained) begin
                    w_state_next = S_WRITE_LEN;
                end else begin
                    w_state_next = S_FLUSH;
                end
            end
            S_WRITE_LEN: begin
                if (w_len_ack) begin
                    w_state_next = S_DONE;
                end else begin
                    w_state_next = S_WRITE_LEN;
                end
            end
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // FIFO, counters and the SDRAM write port
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_base      <= {ADDR_W{1'b0}};
            r_count     <= {ADDR_W{1'b0}};
            r_wr_ptr    <= {PTR_W{1'b0}};
            r_rd_ptr    <= {PTR_W{1'b0}};
            r_occ       <= {OCC_W{1'b0}};
            r_write     <= 1'b0;
            r_addr      <= {ADDR_W{1'b0}};
            r_writedata <= {DATA_W{1'b0}};
            r_length    <= {ADDR_W{1'b0}};
            r_overflow  <= 1'b0;
`ifdef REC_DECIMATE_EN
            r_phase     <= 1'b0;
`endif
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_fifo[i] <= {DATA_W{1'b0}};
            end
        end else if (w_start) begin
            r_base     <= rec_base;
            r_count    <= {ADDR_W{1'b0}};
            r_wr_ptr   <= {PTR_W{1'b0}};
            r_rd_ptr   <= {PTR_W{1'b0}};
            r_occ      <= {OCC_W{1'b0}};
            r_overflow <= 1'b0;
`ifdef REC_DECIMATE_EN
            r_phase    <= 1'b0;
`endif
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= rec_audio_data;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count  <= r_count + ADDR_W'(1);
            end
            r_occ <= r_occ + OCC_W'(w_push) - OCC_W'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
`ifdef REC_DECIMATE_EN
            if (w_accept) begin
                r_phase <= ~r_phase;
            end
`endif
            // The head stays in the FIFO until the write is acknowledged
            if (w_issue) begin
                r_write     <= 1'b1;
                r_addr      <= r_base + ADDR_W'(1) + r_count;
                r_writedata <= r_fifo[r_rd_ptr];
            end else if (w_enter_len) begin
                r_write     <= 1'b1;
                r_addr      <= r_base;
                r_writedata <= DATA_W'(r_count);
            end else if (w_pop || w_len_ack) begin
                r_write <= 1'b0;
            end
            if (w_len_ack) begin
                r_length <= r_count;
            end
        end
    end

    assign rec_busy        = (r_state != S_IDLE);
    assign rec_done        = (r_state == S_DONE);
    assign rec_audio_ready = (r_state == S_RECORD);
    assign rec_length      = r_length;
    assign rec_overflow    = r_overflow;
    assign rec_write       = r_write;
    assign rec_addr        = r_addr;
    assign rec_writedata   = r_writedata;

endmodule

// File: tb/tb_record_core.sv
// Directed bench for record_core: an SDRAM responder logs every committed write, each test task checks
// the logged clip and status outputs against hand-computed values.
module tb_record_core;

    localparam int                ADDR_W     = 23;
    localparam int                DATA_W     = 32;
    localparam int                FIFO_DEPTH = 4;
    localparam logic [ADDR_W-1:0] MAX_LEN    = 23'd5;
`ifdef REC_DECIMATE_EN
    localparam int EXP_ACC = 9;
`else
    localparam int EXP_ACC = 5;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rec_start;
    logic [ADDR_W-1:0] rec_base;
    logic              rec_stop;
    logic              rec_busy;
    logic              rec_done;
    logic [ADDR_W-1:0] rec_length;
    logic              rec_overflow;
    logic              rec_write;
    logic [ADDR_W-1:0] rec_addr;
    logic [DATA_W-1:0] rec_writedata;
    logic              rec_sdram_finished;
    logic              rec_audio_valid;
    logic [DATA_W-1:0] rec_audio_data;
    logic              rec_audio_ready;

    int checks = 0;
    int errors = 0;
    int ack_delay = 0;
    bit hold_ack = 1'b0;
    int wait_cnt = 0;
    int done_cnt = 0;
    logic [ADDR_W-1:0] log_addr [$];
    logic [DATA_W-1:0] log_data [$];

    record_core #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .MAX_LEN(MAX_LEN)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .rec_start(rec_start), .rec_base(rec_base), .rec_stop(rec_stop),
        .rec_busy(rec_busy), .rec_done(rec_done), .rec_length(rec_length),
        .rec_overflow(rec_overflow), .rec_write(rec_write), .rec_addr(rec_addr),
        .rec_writedata(rec_writedata), .rec_sdram_finished(rec_sdram_finished),
        .rec_audio_valid(rec_audio_valid), .rec_audio_data(rec_audio_data),
        .rec_audio_ready(rec_audio_ready)
    );

    always #5 clk = ~clk;

    // SDRAM responder: acknowledges after ack_delay extra cycles, logs committed writes
    initial begin
        rec_sdram_finished = 1'b0;
        forever begin
            @(negedge clk);
            rec_sdram_finished = 1'b0;
            if (rec_write && !hold_ack) begin
                if (wait_cnt >= ack_delay) begin
                    rec_sdram_finished = 1'b1;
                    wait_cnt = 0;
                    log_addr.push_back(rec_addr);
                    log_data.push_back(rec_writedata);
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rec_done) done_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic start_clip(input logic [ADDR_W-1:0] base, input logic with_stop);
        rec_base  = base;
        rec_start = 1'b1;
        rec_stop  = with_stop;
        @(negedge clk);
        rec_start = 1'b0;
        rec_stop  = 1'b0;
    endtask

    task automatic send_samples(input logic [DATA_W-1:0] first, input int n);
        for (int i = 0; i < n; i++) begin
            rec_audio_valid = 1'b1;
            rec_audio_data  = first + DATA_W'(i);
            @(negedge clk);
        end
        rec_audio_valid = 1'b0;
    endtask

    task automatic stop_clip();
        rec_stop = 1'b1;
        @(negedge clk);
        rec_stop = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (rec_done) begin
                timed_out = 1'b0;
                break;
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rec_start = 1'b0; rec_stop = 1'b0; rec_base = '0;
        rec_audio_valid = 1'b0; rec_audio_data = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({rec_busy, rec_done, rec_overflow, rec_write, rec_audio_ready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b want 00000",
                     {rec_busy, rec_done, rec_overflow, rec_write, rec_audio_ready});
        end
        checks++;
        if ({rec_length, rec_addr, rec_writedata} !== {ADDR_W+ADDR_W+DATA_W{1'b0}}) begin
            errors++;
            $display("FAIL reset_buses: got len=%h addr=%h data=%h want 0", rec_length, rec_addr, rec_writedata);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        bit to;
        log_addr.delete(); log_data.delete(); done_cnt = 0; ack_delay = 1;
        start_clip(23'h000100, 1'b0);
        checks++;
        if ({rec_busy, rec_audio_ready} !== 2'b11) begin
            errors++;
            $display("FAIL basic_record_state: got busy/ready=%b want 11", {rec_busy, rec_audio_ready});
        end
        send_samples(32'hA5A5_0000, 3);
        stop_clip();
        wait_done(200, to);
        repeat (2) @(negedge clk);
        checks++;
        if (to) begin errors++; $display("FAIL basic_timeout: got no rec_done want pulse"); end
        checks++;
        if (log_addr.size() != 4) begin
            errors++; $display("FAIL basic_nwrites: got %0d want 4", log_addr.size());
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({log_addr[i], log_data[i]} !== {23'h000101 + ADDR_W'(i), 32'hA5A5_0000 + DATA_W'(i)}) begin
                errors++;
                $display("FAIL basic_sample%0d: got %h=%h want %h=%h", i, log_addr[i], log_data[i],
                         23'h000101 + ADDR_W'(i), 32'hA5A5_0000 + DATA_W'(i));
            end
        end
        checks++;
        if ({log_addr[3], log_data[3]} !== {23'h000100, 32'd3}) begin
            errors++; $display("FAIL basic_lenword: got %h=%h want 000100=3", log_addr[3], log_data[3]);
        end
        checks++;
        if ({done_cnt, rec_length, rec_overflow, rec_busy} !== {32'd1, 23'd3, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL basic_status: got done=%0d len=%0d ovf=%b busy=%b want 1 3 0 0",
                     done_cnt, rec_length, rec_overflow, rec_busy);
        end
    endtask

    task automatic test_zero_len();
        bit to;
        log_addr.delete(); log_data.delete(); done_cnt = 0; ack_delay = 0;
        start_clip(23'h000100, 1'b0);
        stop_clip();
        wait_done(100, to);
        repeat (2) @(negedge clk);
        checks++;
        if (to) begin errors++; $display("FAIL zero_timeout: got no rec_done want pulse"); end
        checks++;
        if (log_addr.size() != 1 || {log_addr[0], log_data[0]} !== {23'h000100, 32'd0}) begin
            errors++;
            $display("FAIL zero_write: got n=%0d %h=%h want n=1 000100=0", log_addr.size(), log_addr[0], log_data[0]);
        end
        checks++;
        if ({done_cnt, rec_length} !== {32'd1, 23'd0}) begin
            errors++; $display("FAIL zero_status: got done=%0d len=%0d want 1 0", done_cnt, rec_length);
        end
    endtask

    task automatic test_overflow();
        bit to;
        log_addr.delete(); log_data.delete(); done_cnt = 0; ack_delay = 0; hold_ack = 1'b1;
        start_clip(23'h000300, 1'b0);
        send_samples(32'h0000_0C00, 6);
        checks++;
        if ({rec_overflow, rec_write, rec_addr} !== {1'b1, 1'b1, 23'h000301}) begin
            errors++;
            $display("FAIL ovf_flag: got ovf=%b write=%b addr=%h want 1 1 000301", rec_overflow, rec_write, rec_addr);
        end
        stop_clip();
        hold_ack = 1'b0;
        wait_done(200, to);
        checks++;
        if (to || log_addr.size() != 5) begin
            errors++; $display("FAIL ovf_nwrites: got %0d timeout=%b want 5 0", log_addr.size(), to);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if ({log_addr[i], log_data[i]} !== {23'h000301 + ADDR_W'(i), 32'h0000_0C00 + DATA_W'(i)}) begin
                errors++;
                $display("FAIL ovf_sample%0d: got %h=%h want %h=%h", i, log_addr[i], log_data[i],
                         23'h000301 + ADDR_W'(i), 32'h0000_0C00 + DATA_W'(i));
            end
        end
        checks++;
        if ({log_addr[4], log_data[4], rec_length, rec_overflow} !== {23'h000300, 32'd4, 23'd4, 1'b1}) begin
            errors++;
            $display("FAIL ovf_len: got %h=%h len=%0d ovf=%b want 000300=4 4 1",
                     log_addr[4], log_data[4], rec_length, rec_overflow);
        end
    endtask

    task automatic test_max_len();
        bit to;
        bit phase = 1'b0;
        int acc = 0;
        logic [DATA_W-1:0] exp_d [$];
        log_addr.delete(); log_data.delete(); done_cnt = 0; ack_delay = 0;
        start_clip(23'h000400, 1'b0);
        checks++;
        if (rec_overflow !== 1'b0) begin
            errors++; $display("FAIL maxlen_ovf_clear: got %b want 0", rec_overflow);
        end
        for (int i = 0; i < 12; i++) begin
            rec_audio_valid = 1'b1;
            rec_audio_data  = 32'hB000_0000 + DATA_W'(i);
            if (rec_audio_ready) begin
                acc++;
                if (!phase) exp_d.push_back(rec_audio_data);
`ifdef REC_DECIMATE_EN
                phase = ~phase;
`endif
            end
            @(negedge clk);
        end
        rec_audio_valid = 1'b0;
        checks++;
        if (acc != EXP_ACC || rec_audio_ready !== 1'b0) begin
            errors++;
            $display("FAIL maxlen_accept: got acc=%0d ready=%b want %0d 0", acc, rec_audio_ready, EXP_ACC);
        end
        wait_done(200, to);
        checks++;
        if (to || log_addr.size() != 6) begin
            errors++; $display("FAIL maxlen_nwrites: got %0d timeout=%b want 6 0", log_addr.size(), to);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if ({log_addr[i], log_data[i]} !== {23'h000401 + ADDR_W'(i), exp_d[i]}) begin
                errors++;
                $display("FAIL maxlen_sample%0d: got %h=%h want %h=%h", i, log_addr[i], log_data[i],
                         23'h000401 + ADDR_W'(i), exp_d[i]);
            end
        end
        checks++;
        if ({log_addr[5], log_data[5], rec_length, rec_overflow} !== {23'h000400, 32'd5, 23'd5, 1'b0}) begin
            errors++;
            $display("FAIL maxlen_len: got %h=%h len=%0d ovf=%b want 000400=5 5 0",
                     log_addr[5], log_data[5], rec_length, rec_overflow);
        end
    endtask

    task automatic test_reset_mid();
        bit to;
        log_addr.delete(); log_data.delete(); done_cnt = 0; ack_delay = 0; hold_ack = 1'b1;
        start_clip(23'h000500, 1'b0);
        send_samples(32'h0000_0D00, 2);
        checks++;
        if ({rec_write, rec_addr} !== {1'b1, 23'h000501}) begin
            errors++; $display("FAIL rstmid_pending: got write=%b addr=%h want 1 000501", rec_write, rec_addr);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if ({rec_busy, rec_done, rec_overflow, rec_write, rec_audio_ready, rec_addr, rec_writedata, rec_length}
            !== {5'b0, {ADDR_W+DATA_W+ADDR_W{1'b0}}}) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b write=%b addr=%h data=%h len=%h want all 0",
                     rec_busy, rec_write, rec_addr, rec_writedata, rec_length);
        end
        rst_n = 1'b1;
        hold_ack = 1'b0;
        repeat (10) @(negedge clk);
        checks++;
        if (log_addr.size() != 0 || rec_busy !== 1'b0) begin
            errors++; $display("FAIL rstmid_abandon: got writes=%0d busy=%b want 0 0", log_addr.size(), rec_busy);
        end
        start_clip(23'h000600, 1'b1);
        checks++;
        if ({rec_busy, rec_audio_ready} !== 2'b11) begin
            errors++; $display("FAIL start_wins: got busy/ready=%b want 11", {rec_busy, rec_audio_ready});
        end
        stop_clip();
        wait_done(100, to);
        checks++;
        if (to || log_addr.size() != 1 || {log_addr[0], log_data[0], rec_length} !== {23'h000600, 32'd0, 23'd0}) begin
            errors++;
            $display("FAIL start_wins_clip: got n=%0d %h=%h len=%0d want 1 000600=0 0",
                     log_addr.size(), log_addr[0], log_data[0], rec_length);
        end
    endtask

`ifdef REC_DECIMATE_EN
    task automatic test_decimate();
        bit to;
        log_addr.delete(); log_data.delete(); done_cnt = 0; ack_delay = 0;
        start_clip(23'h000700, 1'b0);
        send_samples(32'd1, 6);
        stop_clip();
        wait_done(200, to);
        checks++;
        if (to || log_addr.size() != 4) begin
            errors++; $display("FAIL dec_nwrites: got %0d timeout=%b want 4 0", log_addr.size(), to);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({log_addr[i], log_data[i]} !== {23'h000701 + ADDR_W'(i), DATA_W'(2 * i + 1)}) begin
                errors++;
                $display("FAIL dec_sample%0d: got %h=%h want %h=%0d", i, log_addr[i], log_data[i],
                         23'h000701 + ADDR_W'(i), 2 * i + 1);
            end
        end
        checks++;
        if ({log_addr[3], log_data[3], rec_length} !== {23'h000700, 32'd3, 23'd3}) begin
            errors++;
            $display("FAIL dec_len: got %h=%h len=%0d want 000700=3 3", log_addr[3], log_data[3], rec_length);
        end
    endtask
`endif

    initial begin
        rst_n = 1'b0;
        rec_start = 1'b0; rec_stop = 1'b0; rec_base = '0;
        rec_audio_valid = 1'b0; rec_audio_data = '0;
        @(negedge clk);
        test_reset();
`ifdef REC_DECIMATE_EN
        test_zero_len();
        test_decimate();
        test_max_len();
        test_reset_mid();
`else
        test_basic();
        test_zero_len();
        test_overflow();
        test_max_len();
        test_reset_mid();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
